// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg
//
// Shared definitions for the shift-and-subtract divider:
//   DIV_WIDTH      default operand/result width (also the iteration count)
//   DIV_CNT_WIDTH  width of the iteration counter, wide enough to hold WIDTH
//   div_state_e    controller state encoding (IDLE=0 ... DONE=4)
// ---------------------------------------------------------------------------
package div_pkg;

    localparam int DIV_WIDTH     = 16;
    localparam int DIV_CNT_WIDTH = $clog2(DIV_WIDTH) + 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } div_state_e;

endpackage

// File: rtl/subtract_16bit.sv
// ---------------------------------------------------------------------------
// subtract_16bit
//
// Combinational subtractor diff = a - b with borrow-out, built as a
// carry-lookahead adder computing a + ~b + 1. Carries are resolved in
// 4-bit lookahead groups; WIDTH must be a multiple of 4.
//
// Ports:
//   a          in   WIDTH  minuend
//   b          in   WIDTH  subtrahend
//   diff       out  WIDTH  a - b modulo 2^WIDTH
//   borrow_out out  1      1 when a < b (unsigned)
// ---------------------------------------------------------------------------
module subtract_16bit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int GROUPS = WIDTH / 4;

    logic [WIDTH-1:0] b_inv;
    logic [WIDTH-1:0] gen;
    logic [WIDTH-1:0] prop;
    logic [WIDTH:0]   carry;

    assign b_inv = ~b;
    assign gen   = a & b_inv;
    assign prop  = a ^ b_inv;

    // Carry-in of 1 completes the two's-complement of b. Inside each group
    // every carry is a flat sum of products of the group's generate and
    // propagate terms and the group carry-in, so no carry ripples bit to bit.
    always_comb begin
        carry    = '0;
        carry[0] = 1'b1;
        for (int grp = 0; grp < GROUPS; grp++) begin
            carry[grp*4+1] = gen[grp*4]
                           | (prop[grp*4] & carry[grp*4]);
            carry[grp*4+2] = gen[grp*4+1]
                           | (prop[grp*4+1] & gen[grp*4])
                           | (prop[grp*4+1] & prop[grp*4] & carry[grp*4]);
            carry[grp*4+3] = gen[grp*4+2]
                           | (prop[grp*4+2] & gen[grp*4+1])
                           | (prop[grp*4+2] & prop[grp*4+1] & gen[grp*4])
                           | (prop[grp*4+2] & prop[grp*4+1] & prop[grp*4]
                              & carry[grp*4]);
            carry[grp*4+4] = gen[grp*4+3]
                           | (prop[grp*4+3] & gen[grp*4+2])
                           | (prop[grp*4+3] & prop[grp*4+2] & gen[grp*4+1])
                           | (prop[grp*4+3] & prop[grp*4+2] & prop[grp*4+1]
                              & gen[grp*4])
                           | (prop[grp*4+3] & prop[grp*4+2] & prop[grp*4+1]
                              & prop[grp*4] & carry[grp*4]);
        end
    end

    assign diff = prop ^ carry[WIDTH-1:0];

    // No carry out of a + ~b + 1 means the subtraction borrowed.
    assign borrow_out = ~carry[WIDTH];

endmodule

// File: rtl/shift_sub_divider.sv
// ---------------------------------------------------------------------------
// shift_sub_divider
//
// Multi-cycle integer divider using restoring shift-and-subtract, one
// quotient bit per cycle. Operands are captured with a single-cycle start
// pulse while idle; busy is held during PREP/ITER/FIX and done pulses for
// one cycle in DONE with registered results that remain held afterwards.
// Signed division truncates toward zero; the remainder takes the sign of
// the dividend. A zero divisor yields quotient all-ones, remainder equal
// to the raw dividend and div_by_zero set.
//
// Ports:
//   clk          in   1      rising-edge clock
//   rst          in   1      asynchronous active-high reset
//   start        in   1      request, sampled only in IDLE or DONE
//   is_signed    in   1      1 = two's-complement operands
//   dividend     in   WIDTH  numerator
//   divisor      in   WIDTH  denominator
//   busy         out  1      high in PREP, ITER and FIX
//   done         out  1      one-cycle completion pulse
//   quotient     out  WIDTH  registered quotient
//   remainder    out  WIDTH  registered remainder
//   div_by_zero  out  1      registered divide-by-zero flag
// ---------------------------------------------------------------------------
module shift_sub_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int               CNT_W     = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    div_state_e       state_q,     state_d;
    logic [WIDTH-1:0] dividend_q,  dividend_d;
    logic [WIDTH-1:0] divisor_q,   divisor_d;
    logic             neg_dvd_q,   neg_dvd_d;
    logic             neg_dvs_q,   neg_dvs_d;
    logic [WIDTH-1:0] dvsr_q,      dvsr_d;
    logic [WIDTH-1:0] q_sr_q,      q_sr_d;
    logic [WIDTH:0]   rem_q,       rem_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [WIDTH-1:0] quotient_q,  quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q,       dbz_d;

    logic [WIDTH:0]   shifted_rem;
    logic [WIDTH-1:0] trial_diff;
    logic             trial_borrow;
    logic             trial_fits;

    // The quotient shift register's MSB moves into the partial remainder
    // each iteration, so the dividend bits are consumed MSB first while the
    // new quotient bits fill in from the bottom.
    assign shifted_rem = {rem_q[WIDTH-1:0], q_sr_q[WIDTH-1]};

    subtract_16bit #(
        .WIDTH (WIDTH)
    ) u_trial_sub (
        .a          (shifted_rem[WIDTH-1:0]),
        .b          (dvsr_q),
        .diff       (trial_diff),
        .borrow_out (trial_borrow)
    );

    // Any partial remainder with a bit set at or above position WIDTH is
    // larger than every possible divisor, so the subtraction always succeeds
    // and the low WIDTH bits of the difference are exact.
    assign trial_fits = shifted_rem[WIDTH] | rem_q[WIDTH] | ~trial_borrow;

    // State and datapath registers; everything returns to zero / IDLE on
    // reset so an in-flight division is simply discarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            dividend_q  <= '0;
            divisor_q   <= '0;
            neg_dvd_q   <= 1'b0;
            neg_dvs_q   <= 1'b0;
            dvsr_q      <= '0;
            q_sr_q      <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dividend_q  <= dividend_d;
            divisor_q   <= divisor_d;
            neg_dvd_q   <= neg_dvd_d;
            neg_dvs_q   <= neg_dvs_d;
            dvsr_q      <= dvsr_d;
            q_sr_q      <= q_sr_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    // Controller and datapath next-state. Outputs are only reloaded on the
    // way into DONE; the flag alone is cleared when a new request is taken.
    always_comb begin
        state_d     = state_q;
        dividend_d  = dividend_q;
        divisor_d   = divisor_q;
        neg_dvd_d   = neg_dvd_q;
        neg_dvs_d   = neg_dvs_q;
        dvsr_d      = dvsr_q;
        q_sr_d      = q_sr_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    dividend_d = dividend;
                    divisor_d  = divisor;
                    neg_dvd_d  = is_signed & dividend[WIDTH-1];
                    neg_dvs_d  = is_signed & divisor[WIDTH-1];
                    dbz_d      = 1'b0;
                    state_d    = PREP;
                end else begin
                    state_d = IDLE;
                end
            end

            PREP: begin
                if (divisor_q == '0) begin
                    quotient_d  = '1;
                    remainder_d = dividend_q;
                    dbz_d       = 1'b1;
                    state_d     = DONE;
                end else begin
                    // Magnitudes wrap modulo 2^WIDTH: the most negative
                    // value stays 100..0, which is still the correct
                    // unsigned magnitude.
                    q_sr_d  = neg_dvd_q ? -dividend_q : dividend_q;
                    dvsr_d  = neg_dvs_q ? -divisor_q  : divisor_q;
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = ITER;
                end
            end

            ITER: begin
                q_sr_d = {q_sr_q[WIDTH-2:0], trial_fits};
                rem_d  = trial_fits ? {1'b0, trial_diff} : shifted_rem;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d = FIX;
                end
            end

            FIX: begin
                quotient_d  = (neg_dvd_q ^ neg_dvs_q) ? -q_sr_q : q_sr_q;
                remainder_d = neg_dvd_q ? -rem_q[WIDTH-1:0]
                                        :  rem_q[WIDTH-1:0];
                state_d     = DONE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy        = (state_q == PREP) || (state_q == ITER) || (state_q == FIX);
    assign done        = (state_q == DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_shift_sub_divider.sv
// ---------------------------------------------------------------------------
// tb_shift_sub_divider
//
// Self-checking bench for shift_sub_divider: a table of directed vectors
// with hand-computed results, hand-written sequences for ignored/back-to-
// back starts and mid-operation reset, and randomized operations checked
// against an integer-arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_shift_sub_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_signed;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        string       name;
        logic        sgn;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_q;
        logic [15:0] exp_r;
        logic        exp_z;
        int          exp_lat;
    } vec_t;

    vec_t vecs[12];

    shift_sub_divider #(
        .WIDTH (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Global watchdog so a broken design can never hang the run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: every check goes through here.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Reference model: plain integer division with the divide-by-zero rule.
    function automatic void refDivide(input logic sgn, input logic [15:0] a,
                                      input logic [15:0] b,
                                      output logic [15:0] q,
                                      output logic [15:0] r,
                                      output logic z);
        int sa;
        int sb;
        int iq;
        int ir;
        if (b == 16'h0000) begin
            q = 16'hFFFF;
            r = a;
            z = 1'b1;
        end else if (!sgn) begin
            q = a / b;
            r = a % b;
            z = 1'b0;
        end else begin
            sa = $signed(a);
            sb = $signed(b);
            iq = sa / sb;
            ir = sa % sb;
            q  = iq[15:0];
            r  = ir[15:0];
            z  = 1'b0;
        end
    endfunction

    // Called #1 after a posedge (the start edge): drives the request, lets
    // the next edge sample it, then scrambles the inputs so any re-sampling
    // would corrupt the result.
    task automatic launch(input logic sgn, input logic [15:0] a, input logic [15:0] b);
        is_signed = sgn;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        dividend  = 16'($urandom);
        divisor   = 16'($urandom);
        is_signed = 1'($urandom);
    endtask

    // Waits (bounded) for done, counting cycles from the start edge and
    // busy cycles, and checks the result registers stay put until done.
    task automatic waitDone(input int lat_in, output int lat, output int busy_cnt);
        logic [15:0] held_q;
        logic [15:0] held_r;
        int          unstable;
        lat      = lat_in;
        busy_cnt = 0;
        unstable = 0;
        held_q   = quotient;
        held_r   = remainder;
        while (done !== 1'b1 && lat < 60) begin
            if (busy === 1'b1) busy_cnt++;
            if (quotient !== held_q || remainder !== held_r) unstable++;
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("done within bound", {31'd0, done}, 32'd1);
        checkOutput("outputs held while busy", unstable, 0);
    endtask

    task automatic applyStimulus(input logic sgn, input logic [15:0] a,
                                 input logic [15:0] b,
                                 output int lat, output int busy_cnt);
        launch(sgn, a, b);
        checkOutput("flag cleared on start", {31'd0, div_by_zero}, 32'd0);
        waitDone(1, lat, busy_cnt);
    endtask

    initial begin
        int          lat;
        int          busy_cnt;
        int          done_seen;
        logic [15:0] mq;
        logic [15:0] mr;
        logic        mz;
        logic        rs;
        logic [15:0] ra;
        logic [15:0] rb;

        vecs[0]  = '{"u 100/7",        1'b0, 16'd100,  16'd7,    16'd14,   16'd2,    1'b0, 19};
        vecs[1]  = '{"s -7/2",         1'b1, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0, 19};
        vecs[2]  = '{"s 7/-2",         1'b1, 16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001, 1'b0, 19};
        vecs[3]  = '{"u 1234/0",       1'b0, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 2};
        vecs[4]  = '{"s 1234/0",       1'b1, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 2};
        vecs[5]  = '{"s 8000/FFFF",    1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 19};
        vecs[6]  = '{"u FFFF/1",       1'b0, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 19};
        vecs[7]  = '{"u 8000/FFFF",    1'b0, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0, 19};
        vecs[8]  = '{"s 8000/1",       1'b1, 16'h8000, 16'h0001, 16'h8000, 16'h0000, 1'b0, 19};
        vecs[9]  = '{"u 0/5",          1'b0, 16'h0000, 16'h0005, 16'h0000, 16'h0000, 1'b0, 19};
        vecs[10] = '{"s -1/-1",        1'b1, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 19};
        vecs[11] = '{"u 3/7",          1'b0, 16'h0003, 16'h0007, 16'h0000, 16'h0003, 1'b0, 19};

        rst       = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;

        #12;
        checkOutput("reset busy",      {31'd0, busy},        32'd0);
        checkOutput("reset done",      {31'd0, done},        32'd0);
        checkOutput("reset quotient",  {16'd0, quotient},    32'd0);
        checkOutput("reset remainder", {16'd0, remainder},   32'd0);
        checkOutput("reset flag",      {31'd0, div_by_zero}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed table; after each result one idle cycle confirms done
        // is a single pulse and the results are held.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].sgn, vecs[i].a, vecs[i].b, lat, busy_cnt);
            checkOutput({vecs[i].name, " quotient"},  {16'd0, quotient},    {16'd0, vecs[i].exp_q});
            checkOutput({vecs[i].name, " remainder"}, {16'd0, remainder},   {16'd0, vecs[i].exp_r});
            checkOutput({vecs[i].name, " flag"},      {31'd0, div_by_zero}, {31'd0, vecs[i].exp_z});
            checkOutput({vecs[i].name, " latency"},   lat, vecs[i].exp_lat);
            checkOutput({vecs[i].name, " busy cycles"}, busy_cnt, vecs[i].exp_lat - 1);
            @(posedge clk);
            #1;
            checkOutput({vecs[i].name, " done pulse"}, {31'd0, done}, 32'd0);
            checkOutput({vecs[i].name, " held q"}, {16'd0, quotient}, {16'd0, vecs[i].exp_q});
        end

        // Start pulsed mid-iteration is ignored; a start in the done cycle
        // is accepted with no bubble.
        launch(1'b0, 16'd50, 16'd5);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        checkOutput("busy before ignored start", {31'd0, busy}, 32'd1);
        is_signed = 1'b0;
        dividend  = 16'd9;
        divisor   = 16'd3;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitDone(6, lat, busy_cnt);
        checkOutput("ignored start quotient",  {16'd0, quotient},  32'd10);
        checkOutput("ignored start remainder", {16'd0, remainder}, 32'd0);
        checkOutput("ignored start latency",   lat, 19);
        launch(1'b0, 16'd9, 16'd3);
        checkOutput("back-to-back accepted", {31'd0, busy}, 32'd1);
        waitDone(1, lat, busy_cnt);
        checkOutput("back-to-back quotient",  {16'd0, quotient},  32'd3);
        checkOutput("back-to-back remainder", {16'd0, remainder}, 32'd0);
        checkOutput("back-to-back latency",   lat, 19);

        // Reset in the fifth iteration cycle discards the operation.
        launch(1'b0, 16'h7777, 16'h0005);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst = 1'b1;
        #1;
        checkOutput("mid reset busy",      {31'd0, busy},        32'd0);
        checkOutput("mid reset done",      {31'd0, done},        32'd0);
        checkOutput("mid reset quotient",  {16'd0, quotient},    32'd0);
        checkOutput("mid reset remainder", {16'd0, remainder},   32'd0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) done_seen++;
        end
        checkOutput("no done after reset", done_seen, 0);
        applyStimulus(1'b0, 16'd20, 16'd6, lat, busy_cnt);
        checkOutput("post reset quotient",  {16'd0, quotient},  32'd3);
        checkOutput("post reset remainder", {16'd0, remainder}, 32'd2);

        // Randomized operations against the reference model, mixing
        // back-to-back starts with idle gaps.
        for (int n = 0; n < 150; n++) begin
            rs = 1'($urandom);
            ra = 16'($urandom);
            case ($urandom_range(0, 9))
                0:       rb = 16'h0000;
                1:       rb = 16'hFFFF;
                2:       rb = 16'h0001;
                3:       rb = 16'($urandom_range(1, 15));
                default: rb = 16'($urandom);
            endcase
            if ($urandom_range(0, 7) == 0) ra = 16'h8000;
            refDivide(rs, ra, rb, mq, mr, mz);
            applyStimulus(rs, ra, rb, lat, busy_cnt);
            checkOutput("random quotient",  {16'd0, quotient},    {16'd0, mq});
            checkOutput("random remainder", {16'd0, remainder},   {16'd0, mr});
            checkOutput("random flag",      {31'd0, div_by_zero}, {31'd0, mz});
            checkOutput("random latency",   lat, mz ? 2 : 19);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/shift_sub_divider.md
# shift_sub_divider

Multi-cycle 16-bit integer divider for the execute stage: the inverse of the adder datapath, producing quotient and remainder by restoring shift-and-subtract, one quotient bit per cycle. It takes a single-cycle `start` pulse with operands, holds `busy` while iterating, and pulses `done` with registered results. The pipeline stalls on `busy`; the ALU adder tree is unaffected.

## Interface
- `WIDTH`, 16, operand/result width; iteration count equals WIDTH.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only when idle (state IDLE or DONE).
- `is_signed`  in  1  1 = two's-complement operands, 0 = unsigned; captured with `start`.
- `dividend`  in  WIDTH  numerator; captured with `start`.
- `divisor`  in  WIDTH  denominator; captured with `start`.
- `busy`  out  1  high from the cycle after an accepted start until `done`.
- `done`  out  1  one-cycle pulse; results valid this cycle and held afterward.
- `quotient`  out  WIDTH  registered quotient.
- `remainder`  out  WIDTH  registered remainder.
- `div_by_zero`  out  1  registered; set with `done` when divisor was 0.

## Operation
- States: IDLE, PREP, ITER, FIX, DONE.
- IDLE/DONE + `start`: latch operands, sign flags (`is_signed` & operand MSB), go PREP. Without `start`: DONE→IDLE, IDLE stays.
- PREP: divisor==0 → DONE with quotient=all-ones, remainder=raw dividend, `div_by_zero`=1. Otherwise load |dividend| into the quotient shift register, |divisor| into the divisor register, clear a WIDTH+1-bit partial remainder, clear the iteration counter, go ITER.
- ITER (exactly WIDTH cycles): shift {rem, q} left 1; trial = rem − divisor via the subtractor; no borrow → rem=trial, q[0]=1; else rem kept, q[0]=0. Counter reaches WIDTH−1 → FIX.
- FIX: signed only: negate quotient if dividend sign ≠ divisor sign; negate remainder if dividend negative (truncating division, remainder takes dividend's sign). Load output registers, go DONE.
- DONE: `done`=1 for this cycle only.
- Absolute value/negation are modulo 2^WIDTH: signed 0x8000 / 0xFFFF gives quotient 0x8000, remainder 0, no flag.
- `start` in PREP/ITER/FIX is ignored; operands are not re-sampled.
- `div_by_zero` cleared on every accepted start.

## Timing
- Reset values: `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `div_by_zero`=0, state IDLE.
- `start` sampled at edge 0 → PREP at edge 1, ITER edges 2..WIDTH+1, FIX edge WIDTH+2, `done` high during the cycle after edge WIDTH+3 (19 cycles for WIDTH=16).
- Divide-by-zero: `done` 2 cycles after the start edge (PREP→DONE).
- `busy` high in PREP, ITER, FIX; low in IDLE and DONE, so back-to-back start in the `done` cycle is accepted with zero bubble.
- Outputs change only on the FIX→DONE or PREP→DONE transition; stable otherwise.
- `rst` mid-operation: immediate return to IDLE, all outputs to reset values, in-flight result discarded.

## Structure
- Shared package `div_pkg`: state encoding constants (IDLE=0 … DONE=4), default WIDTH, iteration counter width ($clog2(WIDTH)+1).
- One sub-module `subtract_16bit`: combinational A − B with borrow-out, built on the team's carry-lookahead adder with inverted B and carry-in 1; instantiated once in the ITER datapath. Negations in PREP/FIX use plain two's-complement expressions.

## Test plan
- Unsigned 100 / 7 → quotient 14, remainder 2, `div_by_zero`=0, `done` exactly 19 cycles after start edge, `busy` high 18 cycles.
- Signed 0xFFF9 (−7) / 0x0002 → quotient 0xFFFD, remainder 0xFFFF; signed 7 / 0xFFFE → quotient 0xFFFD, remainder 0x0001.
- 0x1234 / 0 (either mode) → quotient 0xFFFF, remainder 0x1234, `div_by_zero`=1, `done` 2 cycles after start; next valid start clears flag.
- Signed 0x8000 / 0xFFFF → quotient 0x8000, remainder 0; unsigned 0xFFFF / 0x0001 → 0xFFFF, 0.
- Start 50/5, pulse `start` with 9/3 during ITER → ignored, result 10/0; assert `start` with 9/3 in the `done` cycle → accepted, result 3/0 19 cycles later.
- Assert `rst` in ITER cycle 5 → outputs zero immediately, no `done`; subsequent 20/6 → 3/2.
